// File: rtl/cmp_mem_pkg.sv
// Shared constants for the Cardinal CMP node memory subsystem.
// Index slices use big-endian bit numbering, where bit 0 is the MSB.
package cmp_mem_pkg;
  localparam int IMEM_DEPTH   = 256;
  localparam int DMEM_DEPTH   = 256;
  localparam int IW           = 32;
  localparam int DW           = 64;
  localparam int CNT_W        = 32;

  localparam int IMEM_IDX_MSB = 22;
  localparam int IMEM_IDX_LSB = 29;
  localparam int DMEM_IDX_MSB = 24;
  localparam int DMEM_IDX_LSB = 31;

  localparam logic [0:IW-1] HALT_INST = 32'h00000000;

  function automatic logic is_halt(input logic [0:IW-1] inst);
    return inst == HALT_INST;
  endfunction
endpackage

// File: rtl/cmp_node_mem_bank.sv
// One node's memories: a combinational-read IMEM and a DMEM with
// synchronous loads and stores. RESET clears only the load register.
module cmp_node_mem_bank
  import cmp_mem_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic [0:IW-1] pc,
  output logic [0:IW-1] inst,
  input  logic [0:31]   addr,
  input  logic [0:DW-1] d_wr,
  output logic [0:DW-1] d_rd,
  input  logic          mem_en,
  input  logic          mem_wr_en
);
  logic [7:0] imem_idx;
  logic [7:0] dmem_idx;
  logic       unused_idx_bits;

  assign imem_idx        = pc[IMEM_IDX_MSB:IMEM_IDX_LSB];
  assign dmem_idx        = addr[DMEM_IDX_MSB:DMEM_IDX_LSB];
  assign unused_idx_bits = ^{pc[0:IMEM_IDX_MSB-1], pc[IMEM_IDX_LSB+1:IW-1],
                             addr[0:DMEM_IDX_MSB-1]};

  // Each array sits in its own scope so both can be called MEM for preload.
  if (1) begin : imem
    logic [0:IW-1] MEM [IMEM_DEPTH];
  end

  if (1) begin : dmem
    logic [0:DW-1] MEM [DMEM_DEPTH];
  end

  assign inst = imem.MEM[imem_idx];

  // A store that arrives during RESET is still performed.
  always_ff @(posedge CLK) begin
    if (mem_en && mem_wr_en)
      dmem.MEM[dmem_idx] <= d_wr;
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      d_rd <= '0;
    else if (mem_en && !mem_wr_en)
      d_rd <= dmem.MEM[dmem_idx];
  end
endmodule

// File: rtl/cmp_node_memory_system.sv
// Four-node Cardinal CMP memory subsystem. It also provides a global cycle
// counter and captures the first cycle on which every core fetches the halt word.
module cmp_node_memory_system
  import cmp_mem_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [0:31]      node0_pc_out,
  output logic [0:31]      node0_inst_in,
  input  logic [0:31]      node0_addr_out,
  input  logic [0:63]      node0_d_out,
  output logic [0:63]      node0_d_in,
  input  logic             node0_memEn,
  input  logic             node0_memWrEn,
  input  logic [0:31]      node1_pc_out,
  output logic [0:31]      node1_inst_in,
  input  logic [0:31]      node1_addr_out,
  input  logic [0:63]      node1_d_out,
  output logic [0:63]      node1_d_in,
  input  logic             node1_memEn,
  input  logic             node1_memWrEn,
  input  logic [0:31]      node2_pc_out,
  output logic [0:31]      node2_inst_in,
  input  logic [0:31]      node2_addr_out,
  input  logic [0:63]      node2_d_out,
  output logic [0:63]      node2_d_in,
  input  logic             node2_memEn,
  input  logic             node2_memWrEn,
  input  logic [0:31]      node3_pc_out,
  output logic [0:31]      node3_inst_in,
  input  logic [0:31]      node3_addr_out,
  input  logic [0:63]      node3_d_out,
  output logic [0:63]      node3_d_in,
  input  logic             node3_memEn,
  input  logic             node3_memWrEn,
  output logic [CNT_W-1:0] cycle_number,
  output logic             all_halted,
  output logic [CNT_W-1:0] halt_cycle,
  output logic             halt_valid
);
  cmp_node_mem_bank bank0 (
    .CLK(CLK), .RESET(RESET), .pc(node0_pc_out), .inst(node0_inst_in),
    .addr(node0_addr_out), .d_wr(node0_d_out), .d_rd(node0_d_in),
    .mem_en(node0_memEn), .mem_wr_en(node0_memWrEn)
  );

  cmp_node_mem_bank bank1 (
    .CLK(CLK), .RESET(RESET), .pc(node1_pc_out), .inst(node1_inst_in),
    .addr(node1_addr_out), .d_wr(node1_d_out), .d_rd(node1_d_in),
    .mem_en(node1_memEn), .mem_wr_en(node1_memWrEn)
  );

  cmp_node_mem_bank bank2 (
    .CLK(CLK), .RESET(RESET), .pc(node2_pc_out), .inst(node2_inst_in),
    .addr(node2_addr_out), .d_wr(node2_d_out), .d_rd(node2_d_in),
    .mem_en(node2_memEn), .mem_wr_en(node2_memWrEn)
  );

  cmp_node_mem_bank bank3 (
    .CLK(CLK), .RESET(RESET), .pc(node3_pc_out), .inst(node3_inst_in),
    .addr(node3_addr_out), .d_wr(node3_d_out), .d_rd(node3_d_in),
    .mem_en(node3_memEn), .mem_wr_en(node3_memWrEn)
  );

  // An unknown fetch makes all_halted X, and X never passes the if-test below.
  assign all_halted = is_halt(node0_inst_in) & is_halt(node1_inst_in) &
                      is_halt(node2_inst_in) & is_halt(node3_inst_in);

  always_ff @(posedge CLK) begin
    if (RESET)
      cycle_number <= '0;
    else
      cycle_number <= cycle_number + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      halt_valid <= 1'b0;
      halt_cycle <= '0;
    end else if (all_halted && !halt_valid) begin
      halt_valid <= 1'b1;
      halt_cycle <= cycle_number;
    end
  end
endmodule

// File: tb/tb_cmp_node_memory_system.sv
// Directed bench for cmp_node_memory_system. Fetch, load/store isolation,
// counter and halt capture are checked against hand-computed values.
module tb_cmp_node_memory_system;
  logic        CLK;
  logic        RESET;
  logic [0:31] node0_pc_out, node1_pc_out, node2_pc_out, node3_pc_out;
  logic [0:31] node0_inst_in, node1_inst_in, node2_inst_in, node3_inst_in;
  logic [0:31] node0_addr_out, node1_addr_out, node2_addr_out, node3_addr_out;
  logic [0:63] node0_d_out, node1_d_out, node2_d_out, node3_d_out;
  logic [0:63] node0_d_in, node1_d_in, node2_d_in, node3_d_in;
  logic        node0_memEn, node1_memEn, node2_memEn, node3_memEn;
  logic        node0_memWrEn, node1_memWrEn, node2_memWrEn, node3_memWrEn;
  logic [31:0] cycle_number;
  logic        all_halted;
  logic [31:0] halt_cycle;
  logic        halt_valid;

  int vectors;
  int miscompares;

  cmp_node_memory_system dut (
    .CLK(CLK), .RESET(RESET),
    .node0_pc_out(node0_pc_out), .node0_inst_in(node0_inst_in),
    .node0_addr_out(node0_addr_out), .node0_d_out(node0_d_out),
    .node0_d_in(node0_d_in), .node0_memEn(node0_memEn), .node0_memWrEn(node0_memWrEn),
    .node1_pc_out(node1_pc_out), .node1_inst_in(node1_inst_in),
    .node1_addr_out(node1_addr_out), .node1_d_out(node1_d_out),
    .node1_d_in(node1_d_in), .node1_memEn(node1_memEn), .node1_memWrEn(node1_memWrEn),
    .node2_pc_out(node2_pc_out), .node2_inst_in(node2_inst_in),
    .node2_addr_out(node2_addr_out), .node2_d_out(node2_d_out),
    .node2_d_in(node2_d_in), .node2_memEn(node2_memEn), .node2_memWrEn(node2_memWrEn),
    .node3_pc_out(node3_pc_out), .node3_inst_in(node3_inst_in),
    .node3_addr_out(node3_addr_out), .node3_d_out(node3_d_out),
    .node3_d_in(node3_d_in), .node3_memEn(node3_memEn), .node3_memWrEn(node3_memWrEn),
    .cycle_number(cycle_number), .all_halted(all_halted),
    .halt_cycle(halt_cycle), .halt_valid(halt_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET = 1'b1;
    {node0_pc_out, node1_pc_out, node2_pc_out, node3_pc_out} = {4{32'h00000004}};
    {node0_addr_out, node1_addr_out, node2_addr_out, node3_addr_out} = '0;
    {node0_d_out, node1_d_out, node2_d_out, node3_d_out} = '0;
    {node0_memEn, node1_memEn, node2_memEn, node3_memEn} = '0;
    {node0_memWrEn, node1_memWrEn, node2_memWrEn, node3_memWrEn} = '0;

    // Word 1 holds a running instruction and word 2 holds the halt word.
    dut.bank0.imem.MEM[1] = 32'h10000001;
    dut.bank1.imem.MEM[1] = 32'h10000002;
    dut.bank2.imem.MEM[1] = 32'h10000003;
    dut.bank3.imem.MEM[1] = 32'h10000004;
    dut.bank0.imem.MEM[2] = 32'h00000000;
    dut.bank1.imem.MEM[2] = 32'h00000000;
    dut.bank2.imem.MEM[2] = 32'h00000000;
    dut.bank3.imem.MEM[2] = 32'h00000000;
    dut.bank0.imem.MEM[3] = 32'h12345678;

    // Reset held for 5 edges
    repeat (5) tick();
    RESET = 1'b0;
    chk("cycle_at_release", cycle_number, 0);
    chk("d_in0_reset", node0_d_in, 0);
    chk("d_in1_reset", node1_d_in, 0);
    chk("d_in2_reset", node2_d_in, 0);
    chk("d_in3_reset", node3_d_in, 0);
    chk("halt_valid_reset", halt_valid, 0);
    chk("halt_cycle_reset", halt_cycle, 0);
    chk("all_halted_running", all_halted, 0);

    // Combinational fetch, no clock edge
    node0_pc_out = 32'h0000000C;
    #1;
    chk("fetch_node0_word3", node0_inst_in, 32'h12345678);

    // Cycle 0: seed word 5 of nodes 0, 1 and 3
    node0_addr_out = 32'h5; node0_d_out = 64'hA0A0A0A0_00000000;
    node1_addr_out = 32'h5; node1_d_out = 64'hA1A1A1A1_11111111;
    node3_addr_out = 32'h5; node3_d_out = 64'hA3A3A3A3_33333333;
    {node0_memEn, node1_memEn, node3_memEn} = 3'b111;
    {node0_memWrEn, node1_memWrEn, node3_memWrEn} = 3'b111;
    tick();
    // Cycle 1: node2 stores to word 5
    {node0_memEn, node1_memEn, node3_memEn} = 3'b000;
    node2_addr_out = 32'h00000005; node2_d_out = 64'hDEADBEEF_CAFEF00D;
    node2_memEn = 1'b1; node2_memWrEn = 1'b1;
    #1;
    chk("store_d_in_before_edge", node2_d_in, 0);
    tick();
    chk("store_no_write_through", node2_d_in, 0);
    // Cycle 2: all nodes load word 5
    node2_memWrEn = 1'b0;
    {node0_memEn, node1_memEn, node3_memEn} = 3'b111;
    {node0_memWrEn, node1_memWrEn, node3_memWrEn} = 3'b000;
    tick();
    chk("load_node2_w5", node2_d_in, 64'hDEADBEEF_CAFEF00D);
    chk("load_node0_w5", node0_d_in, 64'hA0A0A0A0_00000000);
    chk("load_node1_w5", node1_d_in, 64'hA1A1A1A1_11111111);
    chk("load_node3_w5", node3_d_in, 64'hA3A3A3A3_33333333);
    // Cycle 3: node2 stores word 7
    {node0_memEn, node1_memEn, node3_memEn} = 3'b000;
    node2_addr_out = 32'h7; node2_d_out = 64'h77; node2_memWrEn = 1'b1;
    tick();
    // Cycle 4: write enable without memEn does nothing
    node2_memEn = 1'b0; node2_d_out = 64'h1;
    tick();
    chk("memen0_d_in_holds", node2_d_in, 64'hDEADBEEF_CAFEF00D);
    // Cycle 5: reload word 7
    node2_memEn = 1'b1; node2_memWrEn = 1'b0;
    tick();
    chk("memen0_no_store", node2_d_in, 64'h77);
    node2_memEn = 1'b0;
    repeat (4) tick();
    chk("cycle_after_10", cycle_number, 10);

    // Cycle 18: three nodes halted, node1 still running
    repeat (8) tick();
    node0_pc_out = 32'h8; node2_pc_out = 32'h8; node3_pc_out = 32'h8;
    #1;
    chk("partial_all_halted", all_halted, 0);
    tick();
    chk("partial_halt_valid_c19", halt_valid, 0);
    tick();
    chk("partial_halt_valid_c20", halt_valid, 0);
    chk("cycle_at_20", cycle_number, 20);
    node1_pc_out = 32'h8;
    #1;
    chk("all_halted_comb", all_halted, 1);
    tick();
    chk("halt_valid_set", halt_valid, 1);
    chk("halt_cycle_20", halt_cycle, 20);
    {node0_pc_out, node1_pc_out, node2_pc_out, node3_pc_out} = {4{32'h00000004}};
    #1;
    chk("all_halted_cleared", all_halted, 0);
    repeat (3) tick();
    chk("halt_valid_sticky", halt_valid, 1);
    chk("halt_cycle_sticky", halt_cycle, 20);

    // Reset again, with a store still completed during the reset cycle
    RESET = 1'b1;
    node3_addr_out = 32'h9; node3_d_out = 64'h99;
    node3_memEn = 1'b1; node3_memWrEn = 1'b1;
    tick();
    RESET = 1'b0;
    node3_memWrEn = 1'b0;
    chk("reset2_halt_valid", halt_valid, 0);
    chk("reset2_halt_cycle", halt_cycle, 0);
    chk("reset2_cycle", cycle_number, 0);
    chk("reset2_d_in3", node3_d_in, 0);
    tick();
    chk("store_during_reset", node3_d_in, 64'h99);
    node3_memEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
